// File: rtl/encoder_pkg.sv
// Shared types and widths for the pending-vector encoder.
package encoder_pkg;

  localparam int unsigned ENC_IN_W  = 8;
  localparam int unsigned ENC_IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE,
    SCAN
  } enc_state_t;

endpackage

// File: rtl/encoder8_3_pri.sv
// Combinational priority encoder: index of the winning set bit, plus any/single flags.
module encoder8_3_pri
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [ENC_IN_W-1:0]  vec,
  output logic [ENC_IDX_W-1:0] idx,
  output logic                 any,
  output logic                 single
);

  // Later loop iterations override earlier ones, so scan from the losing end.
  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = ENC_IN_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = ENC_IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < ENC_IN_W; i++) begin
        if (vec[i]) idx = ENC_IDX_W'(i);
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    any    = |vec;
    single = any && ((vec & (vec - ENC_IN_W'(1))) == '0);
  end

endmodule

// File: rtl/pending_encoder8_3.sv
// Sequential 8-to-3 encoder: accepts a request vector and streams out the index
// of each set bit, one per handshake, in priority order.
module pending_encoder8_3
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ENC_IN_W-1:0]  in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ENC_IDX_W-1:0] out,
  output logic                 last,
  output logic                 zero_in
);

  enc_state_t           state_q;
  logic [ENC_IN_W-1:0]  pending_q;
  logic                 zero_in_q;

  logic [ENC_IDX_W-1:0] pri_idx;
  logic                 pri_any;
  logic                 pri_single;
  logic [ENC_IN_W-1:0]  pending_cleared;

  encoder8_3_pri #(
    .LSB_FIRST (LSB_FIRST)
  ) u_pri (
    .vec    (pending_q),
    .idx    (pri_idx),
    .any    (pri_any),
    .single (pri_single)
  );

  // Pending vector with the currently presented index removed.
  always_comb begin
    pending_cleared = pending_q & ~(ENC_IN_W'(1) << pri_idx);
  end

  // FSM, pending bits and zero-vector pulse; en low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_in_q <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          zero_in_q <= in_valid && (in == '0);
          if (in_valid && (in != '0)) begin
            pending_q <= in;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          zero_in_q <= 1'b0;
          if (out_ready) begin
            pending_q <= pending_cleared;
            if (pri_single) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state and en (rst only forces in_ready low).
  always_comb begin
    in_ready  = en && !rst && (state_q == IDLE);
    out_valid = en && (state_q == SCAN) && pri_any;
    out       = out_valid ? pri_idx : '0;
    last      = out_valid && pri_single;
    zero_in   = zero_in_q;
  end

endmodule

// File: tb/tb_pending_encoder8_3.sv
// Bench: two encoders (LSB-first and MSB-first) share stimulus and are checked
// every cycle against a behavioural model, plus directed literal expectations.
module tb_pending_encoder8_3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = 8'h00;
  logic       out_ready = 1'b0;

  logic       l_in_ready, l_out_valid, l_last, l_zero;
  logic [2:0] l_out;
  logic       m_in_ready, m_out_valid, m_last, m_zero;
  logic [2:0] m_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pending_encoder8_3 #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(l_in_ready), .in(in_vec),
    .out_valid(l_out_valid), .out_ready(out_ready), .out(l_out), .last(l_last),
    .zero_in(l_zero)
  );

  pending_encoder8_3 #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(m_in_ready), .in(in_vec),
    .out_valid(m_out_valid), .out_ready(out_ready), .out(m_out), .last(m_last),
    .zero_in(m_zero)
  );

  // Model state per instance: 0 = LSB-first, 1 = MSB-first.
  bit         mscan[2] = '{0, 0};
  logic [7:0] mpend[2] = '{8'h00, 8'h00};
  bit         mzero[2] = '{0, 0};

  function automatic int pick(logic [7:0] v, int lsb);
    if (lsb != 0) begin
      for (int i = 0; i < 8; i++) if (v[i]) return i;
    end else begin
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic check(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: list of pending indices consumed one per handshake.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mscan[d] = 0;
        mpend[d] = 8'h00;
        mzero[d] = 0;
      end else if (en) begin
        if (!mscan[d]) begin
          mzero[d] = in_valid && (in_vec == 8'h00);
          if (in_valid && in_vec != 8'h00) begin
            mpend[d] = in_vec;
            mscan[d] = 1;
          end
        end else begin
          mzero[d] = 0;
          if (out_ready) begin
            mpend[d][pick(mpend[d], d == 0 ? 1 : 0)] = 1'b0;
            if (mpend[d] == 8'h00) mscan[d] = 0;
          end
        end
      end
    end
  end

  // Compare process: every output of both instances, every cycle, mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int e_rdy, e_ov, e_out, e_last;
      e_rdy  = (en && !mscan[d] && !rst) ? 1 : 0;
      e_ov   = (en && mscan[d]) ? 1 : 0;
      e_out  = e_ov ? pick(mpend[d], d == 0 ? 1 : 0) : 0;
      e_last = (e_ov && $countones(mpend[d]) == 1) ? 1 : 0;
      if (d == 0) begin
        check("l_in_ready", int'(l_in_ready), e_rdy);
        check("l_out_valid", int'(l_out_valid), e_ov);
        check("l_out", int'(l_out), e_out);
        check("l_last", int'(l_last), e_last);
        check("l_zero_in", int'(l_zero), int'(mzero[0]));
      end else begin
        check("m_in_ready", int'(m_in_ready), e_rdy);
        check("m_out_valid", int'(m_out_valid), e_ov);
        check("m_out", int'(m_out), e_out);
        check("m_last", int'(m_last), e_last);
        check("m_zero_in", int'(m_zero), int'(mzero[1]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(logic [7:0] v, logic ordy);
    in_valid  = 1'b1;
    in_vec    = v;
    out_ready = ordy;
    cyc();
    in_valid  = 1'b0;
    in_vec    = $urandom_range(255, 0);
  endtask

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    en  = 1'b1;
    cyc();

    // Single vector, LSB first: 2, 5, 7.
    load(8'b1010_0100, 1'b1);
    @(negedge clk); check("lit_a4_idx2", int'(l_out), 2); check("lit_a4_last0", int'(l_last), 0);
    cyc();
    @(negedge clk); check("lit_a4_idx5", int'(l_out), 5); check("lit_a4_last1", int'(l_last), 0);
    cyc();
    @(negedge clk); check("lit_a4_idx7", int'(l_out), 7); check("lit_a4_last2", int'(l_last), 1);
    cyc();
    @(negedge clk); check("lit_a4_rdy", int'(l_in_ready), 1);
    cyc();

    // Full vector, MSB first: 7..0, last on 0.
    load(8'hFF, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      check("lit_ff_idx", int'(m_out), i);
      check("lit_ff_last", int'(m_last), i == 0 ? 1 : 0);
      cyc();
    end

    // Backpressure on 8'h81.
    load(8'h81, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("lit_bp_hold", int'(l_out), 0); check("lit_bp_ov", int'(l_out_valid), 1);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk); check("lit_bp_idx0", int'(l_out), 0);
    cyc();
    @(negedge clk); check("lit_bp_idx7", int'(l_out), 7); check("lit_bp_last", int'(l_last), 1);
    cyc();

    // Zero vector.
    load(8'h00, 1'b1);
    @(negedge clk);
    check("lit_zero_pulse", int'(l_zero), 1);
    check("lit_zero_ov", int'(l_out_valid), 0);
    check("lit_zero_rdy", int'(l_in_ready), 1);
    cyc();
    @(negedge clk); check("lit_zero_clr", int'(l_zero), 0);
    cyc();

    // Enable gap mid-scan of 8'h18.
    load(8'h18, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); check("lit_en_ov", int'(l_out_valid), 0); check("lit_en_rdy", int'(l_in_ready), 0);
      cyc();
    end
    en = 1'b1;
    @(negedge clk); check("lit_en_idx3", int'(l_out), 3);
    cyc();
    @(negedge clk); check("lit_en_idx4", int'(l_out), 4); check("lit_en_last", int'(l_last), 1);
    cyc();

    // Async reset mid-scan of 8'hA5.
    load(8'hA5, 1'b0);
    cyc();
    #2 rst = 1'b1;
    #1;
    check("lit_rst_ov", int'(l_out_valid), 0);
    check("lit_rst_out", int'(l_out), 0);
    check("lit_rst_last", int'(l_last), 0);
    cyc();
    #1 rst = 1'b0;
    cyc();
    check("lit_rst_rdy", int'(l_in_ready), 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom_range(7, 0) != 0);
      in_valid  = $urandom_range(1, 0);
      in_vec    = ($urandom_range(5, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 0));
      out_ready = ($urandom_range(3, 0) != 0);
      rst       = ($urandom_range(199, 0) == 0);
      cyc();
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
